// File: rtl/dmem_arb_pkg.sv
// Shared types and default geometry for the data-memory arbiter and the memory it fronts.
// No logic lives here; the memory instance uses the same defaults.
package dmem_arb_pkg;
   localparam int DMEM_ADDR_W = 32;
   localparam int DMEM_DATA_W = 32;
   localparam int DMEM_SIZE   = 128;

   typedef enum logic {IDLE, ACCESS} state_t;

   typedef logic port_id_t;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick, purely combinational; on a tie the port not
// granted last wins. The caller owns the last_gnt history register.
module rr_arbiter2
   import dmem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  port_id_t   last_gnt,
   output logic [1:0] gnt,
   output port_id_t   winner
);

   always_comb begin
      gnt    = 2'b00;
      winner = 1'b0;
      case (req)
         2'b01: begin
            gnt    = 2'b01;
            winner = 1'b0;
         end
         2'b10: begin
            gnt    = 2'b10;
            winner = 1'b1;
         end
         2'b11: begin
            winner = ~last_gnt;
            gnt    = last_gnt ? 2'b01 : 2'b10;
         end
         default: begin
            gnt    = 2'b00;
            winner = 1'b0;
         end
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one data-memory port between MEM stage (port 0) and loader (port 1): grant in IDLE,
// access next cycle, registered done/err/rdata the cycle after; requests wait until granted.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W   = DMEM_ADDR_W,
   parameter int DATA_W   = DMEM_DATA_W,
   parameter int MEM_SIZE = DMEM_SIZE
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m0_gnt,
   output logic              m1_gnt,
   output logic              m0_done,
   output logic              m1_done,
   output logic              m0_err,
   output logic              m1_err,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic              mem_write,
   output logic              mem_read,
   output logic [DATA_W-1:0] mem_write_data,
   input  logic [DATA_W-1:0] mem_read_data
);

   state_t              state_q, state_d;
   port_id_t            last_gnt_q, last_gnt_d;
   port_id_t            lat_port_q, lat_port_d;
   logic                lat_we_q, lat_we_d;
   logic [ADDR_W-1:0]   lat_addr_q, lat_addr_d;
   logic [DATA_W-1:0]   lat_wdata_q, lat_wdata_d;
   logic [1:0]          done_q, done_d;
   logic [1:0]          err_q, err_d;
   logic [DATA_W-1:0]   rdata0_q, rdata0_d;
   logic [DATA_W-1:0]   rdata1_q, rdata1_d;

   logic [1:0]          arb_req;
   logic [1:0]          arb_gnt;
   port_id_t            arb_winner;
   logic                in_access;
   logic                in_range;
   logic [DATA_W-1:0]   resp_rdata;

   assign arb_req = (state_q == IDLE && !rst) ? {m1_req, m0_req} : 2'b00;

   rr_arbiter2 u_arb (
      .req      (arb_req),
      .last_gnt (last_gnt_q),
      .gnt      (arb_gnt),
      .winner   (arb_winner)
   );

   assign m0_gnt = arb_gnt[0];
   assign m1_gnt = arb_gnt[1];

   // rst gates the strobes combinationally so a reset landing in ACCESS never commits a write
   assign in_access      = (state_q == ACCESS) && !rst;
   assign in_range       = lat_addr_q < ADDR_W'(MEM_SIZE);
   assign mem_address    = in_access ? lat_addr_q : '0;
   assign mem_write_data = in_access ? lat_wdata_q : '0;
   assign mem_write      = in_access && in_range && lat_we_q;
   assign mem_read       = in_access && in_range && !lat_we_q;

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      lat_port_d  = lat_port_q;
      lat_we_d    = lat_we_q;
      lat_addr_d  = lat_addr_q;
      lat_wdata_d = lat_wdata_q;
      done_d      = 2'b00;
      err_d       = err_q;
      rdata0_d    = rdata0_q;
      rdata1_d    = rdata1_q;
      resp_rdata  = lat_port_q ? rdata1_q : rdata0_q;
      case (state_q)
         IDLE: begin
            if (|arb_gnt) begin
               state_d     = ACCESS;
               last_gnt_d  = arb_winner;
               lat_port_d  = arb_winner;
               lat_we_d    = arb_winner ? m1_we    : m0_we;
               lat_addr_d  = arb_winner ? m1_addr  : m0_addr;
               lat_wdata_d = arb_winner ? m1_wdata : m0_wdata;
            end
         end
         ACCESS: begin
            state_d            = IDLE;
            done_d[lat_port_q] = 1'b1;
            err_d[lat_port_q]  = !in_range;
            // in-range writes leave the port's last read data in place
            if (!in_range) begin
               resp_rdata = '0;
            end else if (!lat_we_q) begin
               resp_rdata = mem_read_data;
            end
            if (lat_port_q) begin
               rdata1_d = resp_rdata;
            end else begin
               rdata0_d = resp_rdata;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         last_gnt_q  <= 1'b1;
         lat_port_q  <= 1'b0;
         lat_we_q    <= 1'b0;
         lat_addr_q  <= '0;
         lat_wdata_q <= '0;
         done_q      <= 2'b00;
         err_q       <= 2'b00;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         lat_port_q  <= lat_port_d;
         lat_we_q    <= lat_we_d;
         lat_addr_q  <= lat_addr_d;
         lat_wdata_q <= lat_wdata_d;
         done_q      <= done_d;
         err_q       <= err_d;
         rdata0_q    <= rdata0_d;
         rdata1_q    <= rdata1_d;
      end
   end

   assign m0_done  = done_q[0];
   assign m1_done  = done_q[1];
   assign m0_err   = err_q[0];
   assign m1_err   = err_q[1];
   assign m0_rdata = rdata0_q;
   assign m1_rdata = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a 128-word behavioural memory; one table row per cycle.
`timescale 1ns/1ps
module tb_dmem_arbiter;

   logic        clk;
   logic        rst;
   logic        m0_req, m0_we, m1_req, m1_we;
   logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
   logic        m0_gnt, m1_gnt, m0_done, m1_done, m0_err, m1_err;
   logic [31:0] m0_rdata, m1_rdata;
   logic [31:0] mem_address, mem_write_data, mem_read_data;
   logic        mem_write, mem_read;
   logic        mem_init;

   logic [31:0] dmem [128];

   int checks = 0;
   int errors = 0;

   dmem_arbiter dut (
      .clk            (clk),
      .rst            (rst),
      .m0_req         (m0_req),
      .m0_we          (m0_we),
      .m0_addr        (m0_addr),
      .m0_wdata       (m0_wdata),
      .m1_req         (m1_req),
      .m1_we          (m1_we),
      .m1_addr        (m1_addr),
      .m1_wdata       (m1_wdata),
      .m0_gnt         (m0_gnt),
      .m1_gnt         (m1_gnt),
      .m0_done        (m0_done),
      .m1_done        (m1_done),
      .m0_err         (m0_err),
      .m1_err         (m1_err),
      .m0_rdata       (m0_rdata),
      .m1_rdata       (m1_rdata),
      .mem_address    (mem_address),
      .mem_write      (mem_write),
      .mem_read       (mem_read),
      .mem_write_data (mem_write_data),
      .mem_read_data  (mem_read_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] init_val(input int i);
      case (i)
         0: init_val = 32'd5;
         1: init_val = 32'd17;
         2: init_val = 32'd10;
         3: init_val = 32'd28;
         4: init_val = 32'd42;
         5: init_val = 32'd64;
         default: init_val = 32'(i * 3);
      endcase
   endfunction

   // Memory is loaded once at start and is not cleared by the arbiter reset.
   always @(posedge clk) begin
      if (mem_init) begin
         for (int i = 0; i < 128; i++) dmem[i] <= init_val(i);
      end else if (mem_write && mem_address < 32'd128) begin
         dmem[mem_address[6:0]] <= mem_write_data;
      end
   end

   assign mem_read_data = (mem_address < 32'd128) ? dmem[mem_address[6:0]] : 32'h0;

   typedef struct {
      logic        rst;
      logic        r0, w0;
      logic [31:0] a0, d0;
      logic        r1, w1;
      logic [31:0] a1, d1;
      logic [1:0]  gnt;
      logic        mw, mr;
      logic [31:0] ma, md;
      logic [1:0]  done, err;
      logic [31:0] rd0, rd1;
   } vec_t;

   localparam int NV = 31;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic rst_i,
      input logic r0, input logic w0, input logic [31:0] a0, input logic [31:0] d0,
      input logic r1, input logic w1, input logic [31:0] a1, input logic [31:0] d1,
      input logic [1:0] gnt, input logic mw, input logic mr,
      input logic [31:0] ma, input logic [31:0] md,
      input logic [1:0] done, input logic [1:0] err,
      input logic [31:0] rd0, input logic [31:0] rd1);
      vec_t v;
      v.rst = rst_i; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.gnt = gnt; v.mw = mw; v.mr = mr; v.ma = ma; v.md = md;
      v.done = done; v.err = err; v.rd0 = rd0; v.rd1 = rd1;
      return v;
   endfunction

   task automatic chk(input string name, input int row, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got 0x%08h expected 0x%08h", name, row, act, exp);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   initial begin
      //              rst r0 w0 a0            d0            r1 w1 a1            d1     gnt   mw mr ma            md            done  err   rd0           rd1
      vecs[0]  = mk(1, 1, 1, 32'd6,        32'hDEADBEEF, 0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b00, 2'b00, 0,            0);
      vecs[1]  = mk(0, 1, 1, 32'd6,        32'hDEADBEEF, 0, 0, 0,            0,     2'b01, 0, 0, 0,            0,            2'b00, 2'b00, 0,            0);
      vecs[2]  = mk(0, 1, 0, 32'd6,        0,            0, 0, 0,            0,     2'b00, 1, 0, 32'd6,        32'hDEADBEEF, 2'b00, 2'b00, 0,            0);
      vecs[3]  = mk(0, 1, 0, 32'd6,        0,            0, 0, 0,            0,     2'b01, 0, 0, 0,            0,            2'b01, 2'b00, 0,            0);
      vecs[4]  = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 1, 32'd6,        0,            2'b00, 2'b00, 0,            0);
      vecs[5]  = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b01, 2'b00, 32'hDEADBEEF, 0);
      vecs[6]  = mk(1, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b00, 0, 0, 0,            0,            2'b00, 2'b00, 32'hDEADBEEF, 0);
      vecs[7]  = mk(0, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b01, 0, 0, 0,            0,            2'b00, 2'b00, 0,            0);
      vecs[8]  = mk(0, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b00, 0, 1, 32'd0,        0,            2'b00, 2'b00, 0,            0);
      vecs[9]  = mk(0, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b10, 0, 0, 0,            0,            2'b01, 2'b00, 32'd5,        0);
      vecs[10] = mk(0, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b00, 0, 1, 32'd1,        0,            2'b00, 2'b00, 32'd5,        0);
      vecs[11] = mk(0, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b01, 0, 0, 0,            0,            2'b10, 2'b00, 32'd5,        32'd17);
      vecs[12] = mk(0, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b00, 0, 1, 32'd0,        0,            2'b00, 2'b00, 32'd5,        32'd17);
      vecs[13] = mk(0, 1, 0, 32'd0,        0,            1, 0, 32'd1,        0,     2'b10, 0, 0, 0,            0,            2'b01, 2'b00, 32'd5,        32'd17);
      vecs[14] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 1, 32'd1,        0,            2'b00, 2'b00, 32'd5,        32'd17);
      vecs[15] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b10, 2'b00, 32'd5,        32'd17);
      vecs[16] = mk(1, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b00, 2'b00, 32'd5,        32'd17);
      vecs[17] = mk(0, 0, 0, 0,            0,            1, 0, 32'd3,        0,     2'b10, 0, 0, 0,            0,            2'b00, 2'b00, 0,            0);
      vecs[18] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 1, 32'd3,        0,            2'b00, 2'b00, 0,            0);
      vecs[19] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b10, 2'b00, 0,            32'd28);
      vecs[20] = mk(0, 1, 1, 32'd128,      32'h55,       1, 0, 32'hFFFFFFFF, 0,     2'b01, 0, 0, 0,            0,            2'b00, 2'b00, 0,            32'd28);
      vecs[21] = mk(0, 0, 0, 0,            0,            1, 0, 32'hFFFFFFFF, 0,     2'b00, 0, 0, 32'd128,      32'h55,       2'b00, 2'b00, 0,            32'd28);
      vecs[22] = mk(0, 0, 0, 0,            0,            1, 0, 32'hFFFFFFFF, 0,     2'b10, 0, 0, 0,            0,            2'b01, 2'b01, 0,            32'd28);
      vecs[23] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 32'hFFFFFFFF, 0,            2'b00, 2'b01, 0,            32'd28);
      vecs[24] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b10, 2'b11, 0,            0);
      vecs[25] = mk(0, 1, 1, 32'd2,        32'd99,       0, 0, 0,            0,     2'b01, 0, 0, 0,            0,            2'b00, 2'b11, 0,            0);
      vecs[26] = mk(1, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b00, 2'b11, 0,            0);
      vecs[27] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b00, 2'b00, 0,            0);
      vecs[28] = mk(0, 1, 0, 32'd2,        0,            0, 0, 0,            0,     2'b01, 0, 0, 0,            0,            2'b00, 2'b00, 0,            0);
      vecs[29] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 1, 32'd2,        0,            2'b00, 2'b00, 0,            0);
      vecs[30] = mk(0, 0, 0, 0,            0,            0, 0, 0,            0,     2'b00, 0, 0, 0,            0,            2'b01, 2'b00, 32'd10,       0);

      rst = 1'b1; mem_init = 1'b1;
      m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         mem_init = 1'b0;
         rst = vecs[i].rst;
         m0_req = vecs[i].r0; m0_we = vecs[i].w0; m0_addr = vecs[i].a0; m0_wdata = vecs[i].d0;
         m1_req = vecs[i].r1; m1_we = vecs[i].w1; m1_addr = vecs[i].a1; m1_wdata = vecs[i].d1;
         #1;
         chk("gnt",        i, {30'd0, m1_gnt, m0_gnt},   {30'd0, vecs[i].gnt});
         chk("mem_write",  i, {31'd0, mem_write},        {31'd0, vecs[i].mw});
         chk("mem_read",   i, {31'd0, mem_read},         {31'd0, vecs[i].mr});
         chk("mem_address",i, mem_address,               vecs[i].ma);
         chk("mem_wdata",  i, mem_write_data,            vecs[i].md);
         chk("done",       i, {30'd0, m1_done, m0_done}, {30'd0, vecs[i].done});
         chk("err",        i, {30'd0, m1_err, m0_err},   {30'd0, vecs[i].err});
         chk("m0_rdata",   i, m0_rdata,                  vecs[i].rd0);
         chk("m1_rdata",   i, m1_rdata,                  vecs[i].rd1);
      end

      // m0 holds a read request: re-granted every other cycle, done two cycles after each grant
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'd4; m0_wdata = 0;
         m1_req = 1'b0;
         #1;
         chk("b2b_gnt",  100 + k, {31'd0, m0_gnt},  (k % 2 == 0) ? 32'd1 : 32'd0);
         chk("b2b_done", 100 + k, {31'd0, m0_done}, (k >= 2 && k % 2 == 0) ? 32'd1 : 32'd0);
         if (k == 2) chk("b2b_rdata", 100 + k, m0_rdata, 32'd42);
      end
      @(negedge clk);
      m0_req = 1'b0;

      // Low words untouched by the out-of-range write and the reset-aborted write
      for (int i = 0; i < 6; i++) begin
         chk("dmem", 200 + i, dmem[i], init_val(i));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
